thread_fetch_unit: RTL and testbench
====================================

Name: thread_fetch_unit

Overview:
Fetch front end for the 5-thread barrel core. Holds one PC per hardware thread and picks one enabled thread per cycle, round-robin. It drives the 9-bit word address into the combinational instruction memory and registers the returned word, with its PC and thread ID, into the IF/ID stage. Each thread's PC stays confined to its 100-word slot window (thread t owns words t*100 to t*100+99).

Parameters:
NUM_THREADS, 5, number of hardware threads; thread IDs are 0..4.
SLOTS_PER_THREAD, 100, instruction words per thread window.
AW, 9, instruction word address width (512-word memory).

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst  input  1  synchronous, active-high reset.
thread_en  input  5  per-thread fetch enable; bit t enables thread t.
stall  input  1  downstream not ready; freeze the fetch and hold the outputs.
redirect_valid  input  1  load a new PC for one thread (branch/jump resolved).
redirect_tid  input  3  thread being redirected.
redirect_off  input  7  new PC as an offset within that thread's window.
imem_addr  output  9  word address to instruction memory (combinational).
imem_rd  input  32  instruction word returned combinationally for imem_addr.
if_valid  output  1  IF/ID register holds a valid instruction.
if_instr  output  32  registered instruction.
if_pc  output  9  absolute word address of if_instr.
if_tid  output  3  thread ID of if_instr.

Behaviour:
- Reset (synchronous, active-high):
  - pc[t] = t*100.
  - last_tid = 4, so thread 0 is fetched first.
  - if_valid = 0, if_instr = 0, if_pc = 0, if_tid = 0.
  - Reset asserted mid-operation discards any in-flight fetch and pending redirect that cycle.
- Thread selection (combinational): sel is the first enabled thread scanning last_tid+1, last_tid+2, ... modulo 5, including last_tid itself last. none_sel = (thread_en == 0).
- Address: imem_addr = pc[sel] when none_sel = 0, else 0. Zero latency; instruction returns in the same cycle.
- Fetch issues when stall = 0 and none_sel = 0. On issue:
  - last_tid <= sel.
  - pc[sel] <= pc[sel]+1, or sel*100 when pc[sel] == sel*100+99 (wrap within window).
  - IF/ID register <= {1, imem_rd, pc[sel], sel}.
  - Fetch latency: 1 cycle from address to if_valid.
- stall = 0 and none_sel = 1: if_valid <= 0; other outputs hold; no PC or last_tid change.
- stall = 1: no PC increment; last_tid holds; if_instr, if_pc, if_tid and if_valid hold, subject to the redirect rule below.
- Redirect (redirect_valid = 1, tid = redirect_tid):
  - Ignored entirely if redirect_tid > 4 or redirect_off > 99.
  - Otherwise pc[tid] <= tid*100 + redirect_off. This overrides the increment for that thread in the same cycle.
  - If an issuing fetch has sel == tid, it is squashed: if_valid <= 0 and the IF/ID data fields hold. last_tid still advances to sel.
  - If stalled and the held if_tid == tid, if_valid <= 0 (stale wrong-path instruction dropped).
  - A redirect to a disabled thread updates its PC.
- Disabling a thread retains its PC; re-enabling resumes from it. thread_en changes take effect in the same cycle's selection.
- Address arithmetic: t*100 + offset is at most 499, always < 512; no address ever leaves its thread's window.

Test Plan:
1. Reset, then thread_en=11111 with no stall -> if_tid/if_pc sequence over 6 cycles: (0,0),(1,100),(2,200),(3,300),(4,400),(0,1); if_instr matches memory contents at each address.
2. thread_en=00100, redirect tid=2 off=99; then run 3 cycles -> fetched if_pc = 299, 200, 201 (window wrap). Also send redirect off=100 -> ignored, PC unchanged.
3. thread_en=01010 -> thread order 1,3,1,3; threads 0, 2 and 4 are never issued and their PCs are unchanged when later enabled.
4. Hold stall=1 for 3 cycles mid-stream -> if_valid/if_instr/if_pc/if_tid constant and imem_addr constant. Release -> sequence resumes at the next thread with no skip or duplicate.
5. Redirect tid=sel in the issuing cycle, off=10 -> next cycle if_valid=0; that thread's next fetch has if_pc = tid*100+10. During a stall, redirect matching the held if_tid -> if_valid drops to 0.
6. Assert rst mid-stream with a redirect present -> next cycle all outputs are 0 and the first post-reset fetch is (0,0); thread_en=00000 -> if_valid=0 and imem_addr=0.

Source files
------------

// File: rtl/thread_fetch_unit.sv
// rtl/thread_fetch_unit.sv - round-robin fetch front end for the 5-thread barrel core
// Per-thread PCs confined to 100-word windows, combinational imem lookup, IF/ID register.
module thread_fetch_unit #(
  parameter int NUM_THREADS      = 5,
  parameter int SLOTS_PER_THREAD = 100,
  parameter int AW               = 9
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [4:0]    thread_en,
  input  logic          stall,
  input  logic          redirect_valid,
  input  logic [2:0]    redirect_tid,
  input  logic [6:0]    redirect_off,
  output logic [AW-1:0] imem_addr,
  input  logic [31:0]   imem_rd,
  output logic          if_valid,
  output logic [31:0]   if_instr,
  output logic [AW-1:0] if_pc,
  output logic [2:0]    if_tid
);

  logic [AW-1:0] pc [NUM_THREADS];
  logic [2:0]    last_tid;
  logic [2:0]    sel;
  logic          none_sel;
  logic          issue;
  logic          redir_ok;
  logic [AW-1:0] cur_pc;
  logic [AW-1:0] next_pc;

  function automatic logic [AW-1:0] base_of(input logic [2:0] t);
    return AW'(t) * AW'(SLOTS_PER_THREAD);
  endfunction

  // Scan last_tid+1 .. last_tid+NUM_THREADS (mod NUM_THREADS); last_tid itself comes last.
  always_comb begin
    logic [2:0] cand;
    int         idx;
    logic       found;
    sel   = '0;
    found = 1'b0;
    cand  = '0;
    for (int i = 1; i <= NUM_THREADS; i++) begin
      idx = int'(last_tid) + i;
      if (idx >= NUM_THREADS) idx = idx - NUM_THREADS;
      cand = 3'(idx);
      if (!found && thread_en[cand]) begin
        sel   = cand;
        found = 1'b1;
      end
    end
  end

  always_comb begin
    none_sel  = (thread_en == '0);
    issue     = !stall && !none_sel;
    redir_ok  = redirect_valid && (redirect_tid < 3'(NUM_THREADS))
                && (redirect_off < 7'(SLOTS_PER_THREAD));
    cur_pc    = pc[sel];
    next_pc   = (cur_pc == base_of(sel) + AW'(SLOTS_PER_THREAD - 1)) ? base_of(sel)
                                                                      : cur_pc + AW'(1);
    imem_addr = none_sel ? '0 : cur_pc;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int t = 0; t < NUM_THREADS; t++) pc[t] <= base_of(3'(t));
      last_tid <= 3'(NUM_THREADS - 1);
      if_valid <= 1'b0;
      if_instr <= '0;
      if_pc    <= '0;
      if_tid   <= '0;
    end else begin
      // A redirect wins over the sequential increment for the same thread.
      for (int t = 0; t < NUM_THREADS; t++) begin
        if (redir_ok && redirect_tid == 3'(t))
          pc[t] <= base_of(3'(t)) + AW'(redirect_off);
        else if (issue && sel == 3'(t))
          pc[t] <= next_pc;
      end

      if (issue) begin
        last_tid <= sel;
        if (redir_ok && redirect_tid == sel) begin
          if_valid <= 1'b0;
        end else begin
          if_valid <= 1'b1;
          if_instr <= imem_rd;
          if_pc    <= cur_pc;
          if_tid   <= sel;
        end
      end else if (!stall) begin
        if_valid <= 1'b0;
      end else if (redir_ok && redirect_tid == if_tid) begin
        // Held instruction is on the wrong path of the redirected thread.
        if_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_thread_fetch_unit.sv
// tb/tb_thread_fetch_unit.sv - table-driven bench for thread_fetch_unit
// Rows carry inputs, expected imem_addr before the edge and expected IF/ID after it.
module tb_thread_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  thread_en;
  logic        stall;
  logic        redirect_valid;
  logic [2:0]  redirect_tid;
  logic [6:0]  redirect_off;
  logic [8:0]  imem_addr;
  logic [31:0] imem_rd;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [8:0]  if_pc;
  logic [2:0]  if_tid;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem(input logic [8:0] a);
    return {7'h35, a, 7'h2b, a};
  endfunction

  assign imem_rd = mem(imem_addr);

  thread_fetch_unit dut (
    .clk(clk), .rst(rst), .thread_en(thread_en), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_tid(redirect_tid),
    .redirect_off(redirect_off), .imem_addr(imem_addr), .imem_rd(imem_rd),
    .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc), .if_tid(if_tid)
  );

  typedef struct {
    logic        rst;
    logic [4:0]  en;
    logic        stall;
    logic        rv;
    logic [2:0]  rtid;
    logic [6:0]  roff;
    logic        chk_addr;
    logic [8:0]  exp_addr;
    logic        exp_v;
    logic [8:0]  exp_pc;
    logic [2:0]  exp_tid;
    logic [31:0] exp_instr;
  } vec_t;

  vec_t vecs[$];
  int   applied = 0;
  int   miscompares = 0;

  task automatic add(input logic r, input logic [4:0] en, input logic st,
                     input logic rv, input logic [2:0] rtid, input logic [6:0] roff,
                     input logic ca, input logic [8:0] ea,
                     input logic ev, input logic [8:0] epc, input logic [2:0] etid,
                     input logic [31:0] ei);
    vec_t v;
    v.rst = r; v.en = en; v.stall = st; v.rv = rv; v.rtid = rtid; v.roff = roff;
    v.chk_addr = ca; v.exp_addr = ea; v.exp_v = ev; v.exp_pc = epc; v.exp_tid = etid;
    v.exp_instr = ei;
    vecs.push_back(v);
  endtask

  task automatic check_outs(input string name, input logic ev, input logic [8:0] epc,
                            input logic [2:0] etid, input logic [31:0] ei);
    if (if_valid !== ev) begin
      miscompares++;
      $display("FAIL %s if_valid got %0b want %0b", name, if_valid, ev);
    end
    if (if_pc !== epc) begin
      miscompares++;
      $display("FAIL %s if_pc got %0d want %0d", name, if_pc, epc);
    end
    if (if_tid !== etid) begin
      miscompares++;
      $display("FAIL %s if_tid got %0d want %0d", name, if_tid, etid);
    end
    if (if_instr !== ei) begin
      miscompares++;
      $display("FAIL %s if_instr got %h want %h", name, if_instr, ei);
    end
  endtask

  task automatic check_addr(input string name, input logic [8:0] ea);
    if (imem_addr !== ea) begin
      miscompares++;
      $display("FAIL %s imem_addr got %0d want %0d", name, imem_addr, ea);
    end
  endtask

  initial begin
    rst = 1'b1; thread_en = '0; stall = 1'b0;
    redirect_valid = 1'b0; redirect_tid = '0; redirect_off = '0;
    repeat (2) @(posedge clk);

    // reset state
    add(1, 5'b11111, 0, 0, 0, 0,   0, 0,   0, 0,   0, 0);
    // all threads enabled: round robin from thread 0
    add(0, 5'b11111, 0, 0, 0, 0,   1, 0,   1, 0,   0, mem(0));
    add(0, 5'b11111, 0, 0, 0, 0,   1, 100, 1, 100, 1, mem(100));
    add(0, 5'b11111, 0, 0, 0, 0,   1, 200, 1, 200, 2, mem(200));
    add(0, 5'b11111, 0, 0, 0, 0,   1, 300, 1, 300, 3, mem(300));
    add(0, 5'b11111, 0, 0, 0, 0,   1, 400, 1, 400, 4, mem(400));
    add(0, 5'b11111, 0, 0, 0, 0,   1, 1,   1, 1,   0, mem(1));
    // single thread 2: redirect to last slot squashes, then window wrap
    add(0, 5'b00100, 0, 1, 2, 99,  1, 201, 0, 1,   0, mem(1));
    add(0, 5'b00100, 0, 0, 0, 0,   1, 299, 1, 299, 2, mem(299));
    add(0, 5'b00100, 0, 0, 0, 0,   1, 200, 1, 200, 2, mem(200));
    add(0, 5'b00100, 0, 1, 2, 100, 1, 201, 1, 201, 2, mem(201));
    add(0, 5'b00100, 0, 1, 5, 0,   1, 202, 1, 202, 2, mem(202));
    // threads 1 and 3 alternate
    add(0, 5'b01010, 0, 0, 0, 0,   1, 301, 1, 301, 3, mem(301));
    add(0, 5'b01010, 0, 0, 0, 0,   1, 101, 1, 101, 1, mem(101));
    add(0, 5'b01010, 0, 0, 0, 0,   1, 302, 1, 302, 3, mem(302));
    add(0, 5'b01010, 0, 0, 0, 0,   1, 102, 1, 102, 1, mem(102));
    // re-enable all: threads 0, 2, 4 resume untouched
    add(0, 5'b11111, 0, 0, 0, 0,   1, 203, 1, 203, 2, mem(203));
    add(0, 5'b11111, 0, 0, 0, 0,   1, 303, 1, 303, 3, mem(303));
    add(0, 5'b11111, 0, 0, 0, 0,   1, 401, 1, 401, 4, mem(401));
    add(0, 5'b11111, 0, 0, 0, 0,   1, 2,   1, 2,   0, mem(2));
    // three stall cycles, then resume at thread 1
    add(0, 5'b11111, 1, 0, 0, 0,   1, 103, 1, 2,   0, mem(2));
    add(0, 5'b11111, 1, 0, 0, 0,   1, 103, 1, 2,   0, mem(2));
    add(0, 5'b11111, 1, 0, 0, 0,   1, 103, 1, 2,   0, mem(2));
    add(0, 5'b11111, 0, 0, 0, 0,   1, 103, 1, 103, 1, mem(103));
    add(0, 5'b11111, 0, 0, 0, 0,   1, 204, 1, 204, 2, mem(204));
    // redirect of the issuing thread 3 to offset 10
    add(0, 5'b11111, 0, 1, 3, 10,  1, 304, 0, 204, 2, mem(204));
    add(0, 5'b11111, 0, 0, 0, 0,   1, 402, 1, 402, 4, mem(402));
    add(0, 5'b11111, 0, 0, 0, 0,   1, 3,   1, 3,   0, mem(3));
    add(0, 5'b11111, 0, 0, 0, 0,   1, 104, 1, 104, 1, mem(104));
    add(0, 5'b11111, 0, 0, 0, 0,   1, 205, 1, 205, 2, mem(205));
    add(0, 5'b11111, 0, 0, 0, 0,   1, 310, 1, 310, 3, mem(310));
    // stalled redirect matching held tid drops it; non-matching keeps it
    add(0, 5'b11111, 1, 1, 3, 0,   1, 403, 0, 310, 3, mem(310));
    add(0, 5'b11111, 0, 0, 0, 0,   1, 403, 1, 403, 4, mem(403));
    add(0, 5'b11111, 1, 1, 0, 50,  1, 4,   1, 403, 4, mem(403));
    add(0, 5'b11111, 0, 0, 0, 0,   1, 50,  1, 50,  0, mem(50));
    // reset mid-stream with a redirect present
    add(1, 5'b11111, 0, 1, 1, 5,   1, 105, 0, 0,   0, 0);
    add(0, 5'b11111, 0, 0, 0, 0,   1, 0,   1, 0,   0, mem(0));
    // no thread enabled; redirect to a disabled thread still lands
    add(0, 5'b00000, 0, 0, 0, 0,   1, 0,   0, 0,   0, mem(0));
    add(0, 5'b00000, 0, 1, 1, 7,   1, 0,   0, 0,   0, mem(0));
    add(0, 5'b00010, 0, 0, 0, 0,   1, 107, 1, 107, 1, mem(107));

    foreach (vecs[i]) begin
      @(negedge clk);
      rst = vecs[i].rst; thread_en = vecs[i].en; stall = vecs[i].stall;
      redirect_valid = vecs[i].rv; redirect_tid = vecs[i].rtid; redirect_off = vecs[i].roff;
      #1;
      applied++;
      if (vecs[i].chk_addr) check_addr($sformatf("row%0d", i), vecs[i].exp_addr);
      @(posedge clk);
      #1;
      check_outs($sformatf("row%0d", i), vecs[i].exp_v, vecs[i].exp_pc,
                 vecs[i].exp_tid, vecs[i].exp_instr);
    end

    // Thread 0 alone for 100 fetches: walks offsets 1..99 and wraps to 0.
    for (int k = 0; k < 100; k++) begin
      logic [8:0] e;
      e = 9'((1 + k) % 100);
      @(negedge clk);
      rst = 1'b0; thread_en = 5'b00001; stall = 1'b0; redirect_valid = 1'b0;
      #1;
      applied++;
      check_addr($sformatf("wrap%0d", k), e);
      @(posedge clk);
      #1;
      check_outs($sformatf("wrap%0d", k), 1'b1, e, 3'd0, mem(e));
    end

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule
